alu_stage: RTL and testbench

- Stage 3 [Execute] of the rv32i pipeline. It consumes the forwarded operands (fwd_rs1_rdata/fwd_rs2_rdata) and alu_force_stall from the forward unit, together with decoded fields from [Decode].
- It computes the ALU result and resolves branches/jumps.
- It registers everything into the stage-4 [Mem] pipeline register. That register drives alu_rd, alu_rd_w_en, alu_rd_valid, alu_rd_data and mem_en back into the forward unit and on to [Mem].

---
 rtl/alu_stage_pkg.sv | 53 +++++
 rtl/alu_stage_core.sv | 38 +++
 rtl/alu_stage.sv | 142 ++++++++++++++
 tb/tb_alu_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_stage_pkg.sv
// Shared rv32i encodings for the Execute stage: ALU ops, instruction classes,
// branch funct3 codes and the stage-4 pipeline register layout.
package alu_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [3:0] {
    TYPE_OP     = 4'd0,
    TYPE_OP_IMM = 4'd1,
    TYPE_LUI    = 4'd2,
    TYPE_AUIPC  = 4'd3,
    TYPE_JAL    = 4'd4,
    TYPE_JALR   = 4'd5,
    TYPE_BRANCH = 4'd6,
    TYPE_LOAD   = 4'd7,
    TYPE_STORE  = 4'd8,
    TYPE_CSR    = 4'd9,
    TYPE_SYSTEM = 4'd10
  } instr_type_e;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [4:0] ZERO_REG_ADDR = 5'd0;

  typedef struct packed {
    logic        en;
    logic        w_en;
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic [3:0]  itype;
    logic [2:0]  funct3;
    logic [31:0] store_data;
  } stage4_t;

endpackage

// File: rtl/alu_stage_core.sv
// Combinational rv32i ALU plus the three comparisons branch resolution needs.
module alu_core
  import alu_stage_pkg::*;
(
  input  logic [3:0]  alu_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o,
  output logic        eq_o,
  output logic        lt_o,
  output logic        ltu_o
);

  logic [4:0] shamt;

  assign shamt = b_i[4:0];
  assign eq_o  = (a_i == b_i);
  assign lt_o  = ($signed(a_i) < $signed(b_i));
  assign ltu_o = (a_i < b_i);

  always_comb begin
    y_o = '0;
    case (alu_op_e'(alu_op_i))
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLL:  y_o = a_i << shamt;
      ALU_SLT:  y_o = {31'd0, lt_o};
      ALU_SLTU: y_o = {31'd0, ltu_o};
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> shamt;
      ALU_SRA:  y_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_stage.sv
// rv32i Execute stage: operand select, ALU, branch/jump redirect and the
// stage-4 [Mem] pipeline register.
module alu_stage
  import alu_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_en,
  input  logic [3:0]  instr_type,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        alu_force_stall,
  input  logic        mem_stall,
  input  logic        flush,
  output logic        alu_stall,
  output logic        change_pc,
  output logic [31:0] next_pc,
  output logic [4:0]  alu_rd,
  output logic        alu_rd_w_en,
  output logic        alu_rd_valid,
  output logic [31:0] alu_rd_data,
  output logic [31:0] alu_pc,
  output logic [3:0]  alu_instr_type,
  output logic [2:0]  alu_funct3,
  output logic [31:0] alu_store_data,
  output logic        mem_en
);

  instr_type_e ty;
  logic        use_imm;
  logic [31:0] op_b;
  logic [31:0] alu_y;
  logic        cmp_eq, cmp_lt, cmp_ltu;
  logic [31:0] rs1_imm, pc_imm, pc_plus4;
  logic [31:0] result;
  logic        br_taken;
  logic        fire;
  stage4_t     s4_d, s4_q;

  assign ty      = instr_type_e'(instr_type);
  assign use_imm = ty inside {TYPE_OP_IMM, TYPE_LOAD, TYPE_STORE, TYPE_JALR};
  assign op_b    = use_imm ? imm : rs2_data;

  alu_core u_core (
    .alu_op_i (alu_op),
    .a_i      (rs1_data),
    .b_i      (op_b),
    .y_o      (alu_y),
    .eq_o     (cmp_eq),
    .lt_o     (cmp_lt),
    .ltu_o    (cmp_ltu)
  );

  // Dedicated adders so address/link/target do not depend on the decoded alu_op.
  assign rs1_imm  = rs1_data + imm;
  assign pc_imm   = pc + imm;
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    result = '0;
    case (ty)
      TYPE_OP, TYPE_OP_IMM:   result = alu_y;
      TYPE_LUI:               result = imm;
      TYPE_AUIPC:             result = pc_imm;
      TYPE_JAL, TYPE_JALR:    result = pc_plus4;
      TYPE_LOAD, TYPE_STORE:  result = rs1_imm;
      TYPE_CSR:               result = rs1_data;
      default:                result = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      BR_BEQ:  br_taken = cmp_eq;
      BR_BNE:  br_taken = !cmp_eq;
      BR_BLT:  br_taken = cmp_lt;
      BR_BGE:  br_taken = !cmp_lt;
      BR_BLTU: br_taken = cmp_ltu;
      BR_BGEU: br_taken = !cmp_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  assign alu_stall = alu_force_stall | mem_stall;
  assign fire      = alu_en & !alu_stall & !flush;
  assign change_pc = fire & ((ty == TYPE_JAL) | (ty == TYPE_JALR) |
                             ((ty == TYPE_BRANCH) & br_taken));
  assign next_pc   = (ty == TYPE_JALR) ? (rs1_imm & ~32'h1) : pc_imm;

  // flush beats mem_stall beats the load-use bubble beats a normal advance.
  always_comb begin
    s4_d = s4_q;
    if (flush) begin
      s4_d.en   = 1'b0;
      s4_d.w_en = 1'b0;
    end else if (mem_stall) begin
      s4_d = s4_q;
    end else if (alu_force_stall) begin
      s4_d.en   = 1'b0;
      s4_d.w_en = 1'b0;
    end else begin
      s4_d.en         = alu_en;
      s4_d.w_en       = alu_en & (rd != ZERO_REG_ADDR) &
                        !(ty inside {TYPE_BRANCH, TYPE_STORE, TYPE_SYSTEM});
      s4_d.valid      = !(ty inside {TYPE_LOAD, TYPE_CSR});
      s4_d.rd         = rd;
      s4_d.data       = result;
      s4_d.pc         = pc;
      s4_d.itype      = instr_type;
      s4_d.funct3     = funct3;
      s4_d.store_data = rs2_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s4_q    <= '0;
      s4_q.pc <= RESET_PC;
    end else begin
      s4_q <= s4_d;
    end
  end

  assign mem_en         = s4_q.en;
  assign alu_rd_w_en    = s4_q.w_en;
  assign alu_rd_valid   = s4_q.valid;
  assign alu_rd         = s4_q.rd;
  assign alu_rd_data    = s4_q.data;
  assign alu_pc         = s4_q.pc;
  assign alu_instr_type = s4_q.itype;
  assign alu_funct3     = s4_q.funct3;
  assign alu_store_data = s4_q.store_data;

endmodule

// File: tb/tb_alu_stage.sv
// Randomized and directed checks of alu_stage against a behavioural rv32i model.
module tb_alu_stage;
  import alu_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        t_en = 1'b0;
  logic [3:0]  t_ty = '0;
  logic [3:0]  t_op = '0;
  logic [2:0]  t_f3 = '0;
  logic [31:0] t_pc = '0;
  logic [31:0] t_imm = '0;
  logic [4:0]  t_rd = '0;
  logic [31:0] t_a = '0;
  logic [31:0] t_b = '0;
  logic        t_fs = 1'b0;
  logic        t_ms = 1'b0;
  logic        t_fl = 1'b0;

  logic        alu_stall, change_pc, alu_rd_w_en, alu_rd_valid, mem_en;
  logic [31:0] next_pc, alu_rd_data, alu_pc, alu_store_data;
  logic [4:0]  alu_rd;
  logic [3:0]  alu_instr_type;
  logic [2:0]  alu_funct3;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Behavioural view of the stage-4 register.
  logic        m_en, m_wen, m_valid, m_known, m_dk;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_pc, m_sd;
  logic [3:0]  m_ty;
  logic [2:0]  m_f3;

  alu_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .alu_en(t_en), .instr_type(t_ty), .alu_op(t_op),
    .funct3(t_f3), .pc(t_pc), .imm(t_imm), .rd(t_rd), .rs1_data(t_a),
    .rs2_data(t_b), .alu_force_stall(t_fs), .mem_stall(t_ms), .flush(t_fl),
    .alu_stall(alu_stall), .change_pc(change_pc), .next_pc(next_pc),
    .alu_rd(alu_rd), .alu_rd_w_en(alu_rd_w_en), .alu_rd_valid(alu_rd_valid),
    .alu_rd_data(alu_rd_data), .alu_pc(alu_pc), .alu_instr_type(alu_instr_type),
    .alu_funct3(alu_funct3), .alu_store_data(alu_store_data), .mem_en(mem_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] wide;
    int unsigned sh;
    sh = int'(y % 32);
    case (op)
      4'd0: return x + y;
      4'd1: return x + (~y + 32'd1);
      4'd2: return x << sh;
      4'd3: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd4: return (x < y) ? 32'd1 : 32'd0;
      4'd5: return x ^ y;
      4'd6: return x >> sh;
      4'd7: begin
        wide = {{32{x[31]}}, x} >> sh;
        return wide[31:0];
      end
      4'd8: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'b000: return x == y;
      3'b001: return x != y;
      3'b100: return $signed(x) < $signed(y);
      3'b101: return $signed(x) >= $signed(y);
      3'b110: return x < y;
      3'b111: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_wen = 0; m_valid = 0; m_rd = '0; m_data = '0; m_pc = RST_PC;
    m_sd = '0; m_ty = '0; m_f3 = '0; m_known = 1; m_dk = 1;
  endtask

  task automatic check_regs();
    chk("mem_en", {31'd0, mem_en}, {31'd0, m_en});
    chk("rd_w_en", {31'd0, alu_rd_w_en}, {31'd0, m_wen});
    if (m_known) begin
      chk("rd_valid", {31'd0, alu_rd_valid}, {31'd0, m_valid});
      chk("rd", {27'd0, alu_rd}, {27'd0, m_rd});
      chk("pc", alu_pc, m_pc);
      chk("itype", {28'd0, alu_instr_type}, {28'd0, m_ty});
      chk("funct3", {29'd0, alu_funct3}, {29'd0, m_f3});
      chk("store_data", alu_store_data, m_sd);
      if (m_dk) chk("rd_data", alu_rd_data, m_data);
    end
  endtask

  task automatic step(input logic en, input logic [3:0] ty, input logic [3:0] op,
                      input logic [2:0] f3, input logic [31:0] pcv, input logic [31:0] immv,
                      input logic [4:0] rdv, input logic [31:0] a, input logic [31:0] b,
                      input logic fs, input logic ms, input logic fl);
    logic [31:0] bsel, res, tgt;
    bit fire, jump, dk;
    @(negedge clk);
    t_en = en; t_ty = ty; t_op = op; t_f3 = f3; t_pc = pcv; t_imm = immv;
    t_rd = rdv; t_a = a; t_b = b; t_fs = fs; t_ms = ms; t_fl = fl;
    #1;
    fire = en && !fs && !ms && !fl;
    jump = (ty == 4'd4) || (ty == 4'd5) || (ty == 4'd6 && ref_taken(f3, a, b));
    tgt  = (ty == 4'd5) ? ((a + immv) & 32'hFFFF_FFFE) : (pcv + immv);
    chk("alu_stall", {31'd0, alu_stall}, {31'd0, fs | ms});
    chk("change_pc", {31'd0, change_pc}, {31'd0, fire && jump});
    if (fire && jump) chk("next_pc", next_pc, tgt);
    bsel = (ty == 4'd1 || ty == 4'd7 || ty == 4'd8 || ty == 4'd5) ? immv : b;
    dk = 1;
    case (ty)
      4'd0, 4'd1: res = ref_alu(op, a, bsel);
      4'd2:       res = immv;
      4'd3:       res = pcv + immv;
      4'd4, 4'd5: res = pcv + 32'd4;
      4'd7, 4'd8: res = a + immv;
      4'd9:       res = a;
      default: begin res = '0; dk = 0; end
    endcase
    @(posedge clk);
    if (fl || (!ms && fs)) begin
      m_en = 0; m_wen = 0; m_known = 0;
    end else if (!ms) begin
      m_en = en;
      m_wen = en && (rdv != 0) && !(ty == 4'd6 || ty == 4'd8 || ty == 4'd10);
      m_valid = !(ty == 4'd7 || ty == 4'd9);
      m_rd = rdv; m_data = res; m_pc = pcv; m_ty = ty; m_f3 = f3; m_sd = b;
      m_known = 1; m_dk = dk;
    end
    #1;
    check_regs();
  endtask

  initial begin
    logic [4:0]  h_rd;
    logic [31:0] h_data, h_pc;
    model_reset();
    #12;
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_pc", alu_pc, RST_PC);
    check_regs();
    @(negedge clk); rst = 1'b0;

    // ADD overflow wraps
    step(1, 4'd0, 4'd0, 3'd0, 32'h10, 32'd0, 5'd5, 32'h7FFF_FFFF, 32'd1, 0, 0, 0);
    chk("add_data", alu_rd_data, 32'h8000_0000);
    chk("add_wen", {31'd0, alu_rd_w_en}, 32'd1);

    // BLT signed vs BLTU
    step(1, 4'd6, 4'd0, 3'b100, 32'h100, 32'hFFFF_FFF8, 5'd7, 32'hFFFF_FFFF, 32'd1, 0, 0, 0);
    chk("blt_chg", {31'd0, change_pc}, 32'd1);
    chk("blt_tgt", next_pc, 32'hF8);
    step(1, 4'd6, 4'd0, 3'b110, 32'h100, 32'hFFFF_FFF8, 5'd7, 32'hFFFF_FFFF, 32'd1, 0, 0, 0);
    chk("bltu_chg", {31'd0, change_pc}, 32'd0);

    // JALR alignment
    step(1, 4'd5, 4'd0, 3'd0, 32'h40, 32'd0, 5'd1, 32'h203, 32'd9, 0, 0, 0);
    chk("jalr_tgt", next_pc, 32'h202);
    chk("jalr_link", alu_rd_data, 32'h44);

    // Load-use bubble, then retry; a taken branch under stall does not redirect
    step(1, 4'd0, 4'd0, 3'd0, 32'h50, 32'd0, 5'd4, 32'd3, 32'd4, 1, 0, 0);
    chk("lu_bubble", {31'd0, mem_en}, 32'd0);
    step(1, 4'd0, 4'd0, 3'd0, 32'h50, 32'd0, 5'd4, 32'd3, 32'd4, 0, 0, 0);
    chk("lu_retry", {31'd0, mem_en}, 32'd1);
    step(1, 4'd6, 4'd0, 3'b000, 32'h60, 32'd16, 5'd0, 32'd2, 32'd2, 1, 0, 0);

    // mem_stall holds a LOAD for three cycles, then flush wins over the stall
    step(1, 4'd7, 4'd0, 3'b010, 32'h80, 32'd4, 5'd3, 32'h200, 32'd0, 0, 0, 0);
    h_rd = alu_rd; h_data = alu_rd_data; h_pc = alu_pc;
    for (int i = 0; i < 3; i++) begin
      step(1, 4'd0, 4'd0, 3'd0, $urandom, $urandom, 5'd9, $urandom, $urandom, 0, 1, 0);
      chk("hold_valid", {31'd0, alu_rd_valid}, 32'd0);
      chk("hold_data", alu_rd_data, 32'h204);
    end
    step(1, 4'd0, 4'd0, 3'd0, 32'h90, 32'd0, 5'd9, 32'd1, 32'd1, 0, 1, 1);
    chk("flush_stall", {31'd0, mem_en}, 32'd0);

    // Asynchronous reset with a valid instruction in stage 4
    step(1, 4'd0, 4'd0, 3'd0, 32'hA0, 32'd0, 5'd6, 32'd1, 32'd2, 0, 0, 0);
    @(negedge clk); #2 rst = 1'b1; #1;
    chk("arst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("arst_wen", {31'd0, alu_rd_w_en}, 32'd0);
    chk("arst_pc", alu_pc, RST_PC);
    model_reset();
    @(negedge clk); rst = 1'b0;
    step(1, 4'd0, 4'd0, 3'd0, 32'hB0, 32'd0, 5'd0, 32'd1, 32'd2, 0, 0, 0);
    chk("x0_wen", {31'd0, alu_rd_w_en}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? b : $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = b;
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 10)), 4'($urandom_range(0, 9)),
           3'($urandom), $urandom, $urandom, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
           a, b, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
